guihca_serial_rx: RTL



---
 rtl/guihca_serial_rx.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/guihca_serial_rx.sv
// guihca_serial_rx: 8N1 serial byte receiver.
// The asynchronous line is synchronised through two flops. A baud counter
// places every sample in the middle of a bit, using a half-bit offset taken
// from the start bit. Each good byte is presented on data_out with a
// one-cycle data_valid strobe and is counted in byte_count. A stop bit
// sampled low raises a one-cycle frame_err pulse. The receiver then waits in
// BREAK until the line returns high.
module guihca_serial_rx #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd1042
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] byte_count
);

  // Sample points, relative to the cycle in which the current state or bit began.
  localparam logic [15:0] FULL_PT = CLKS_PER_BIT - 16'd1;
  localparam logic [15:0] HALF_PT = (CLKS_PER_BIT - 16'd1) >> 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic        r_frame_err;
  logic        r_busy;
  logic [7:0]  r_byte_count;

  logic        w_rx_s;
  logic        w_half;
  logic        w_full;
  logic        w_shift_en;
  logic        w_bit_clr;
  logic        w_good;
  logic        w_bad;
  logic        w_cnt_clr;

  assign w_rx_s = r_sync2;
  assign w_half = (r_cnt == HALF_PT);
  assign w_full = (r_cnt == FULL_PT);

  // Two-flop synchroniser. Both flops reset high so the line reads as idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. All decisions use the synchronised line only.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        // A start bit that is already high again at mid-bit is a glitch.
        if (w_half) begin
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_full && (r_bit_idx == 3'd7)) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit leaves time to catch a following start edge.
        if (w_full) begin
          w_state_nxt = w_rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        // Hold here while the line is low so a held-low line cannot start a new frame.
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output and strobe decode: datapath enables derived from state and sample points.
  always_comb begin
    w_shift_en = 1'b0;
    w_bit_clr  = 1'b0;
    w_good     = 1'b0;
    w_bad      = 1'b0;
    case (r_state)
      S_START: begin
        w_bit_clr = w_half && !w_rx_s;
      end
      S_DATA: begin
        w_shift_en = w_full;
      end
      S_STOP: begin
        w_good = w_full && w_rx_s;
        w_bad  = w_full && !w_rx_s;
      end
      default: begin
        w_shift_en = 1'b0;
      end
    endcase
    // The counter restarts on each state change and at each data-bit boundary.
    // It is held at zero while idle.
    w_cnt_clr = (w_state_nxt != r_state) || w_shift_en || (r_state == S_IDLE);
  end

  // Baud counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (w_cnt_clr) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Bit index and LSB-first shift register. Each new bit enters at bit 7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else if (w_bit_clr) begin
      r_bit_idx <= 3'd0;
    end else if (w_shift_en) begin
      r_bit_idx <= r_bit_idx + 3'd1;
      r_shift   <= {w_rx_s, r_shift[7:1]};
    end
  end

  // Result registers. data_out and byte_count change only on a good stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= 8'h00;
      r_byte_count <= 8'h00;
    end else if (w_good) begin
      r_data_out   <= r_shift;
      r_byte_count <= r_byte_count + 8'd1;
    end
  end

  // One-cycle strobes and the registered busy flag. busy tracks the state
  // entered on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= w_good;
      r_frame_err  <= w_bad;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;
  assign byte_count = r_byte_count;

endmodule
